// File: rtl/apb_pkg.sv
// Shared state encoding, default address map and slave slot names for the
// APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} apb_state_e;

    localparam logic [31:0] SLV_BASE      = 32'h1000_0000;
    localparam int          SLV_SPAN_LOG2 = 12;

    localparam int RAM  = 0;
    localparam int GPO  = 1;
    localparam int GPI  = 2;
    localparam int GPIO = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps a byte address onto one of NUM_SLV
// equal-sized windows above SLV_BASE, giving a one-hot select, index and hit.
module apb_addr_decoder #(
    parameter int                NUM_SLV       = 4,
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE      = apb_pkg::SLV_BASE,
    parameter int                SLV_SPAN_LOG2 = apb_pkg::SLV_SPAN_LOG2,
    parameter int                IDX_W         = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic [IDX_W-1:0]   idx,
    output logic               hit
);

    logic [ADDR_W-1:0] slot;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        sel  = '0;
        idx  = '0;
        hit  = 1'b0;
        slot = (addr - SLV_BASE) >> SLV_SPAN_LOG2;
        // The lower-bound test matters: below the base the subtraction wraps.
        if (addr >= SLV_BASE && slot < ADDR_W'(NUM_SLV)) begin
            hit      = 1'b1;
            idx      = IDX_W'(slot);
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_nslv.sv
// APB3 master bridge: one CPU request at a time onto NUM_SLV decoded slaves,
// with wait states, PSLVERR forwarding and decode errors. Defining
// APB_TIMEOUT_EN adds an abort of ACCESS phases that exceed TIMEOUT_CYC.
module apb_master_nslv
    import apb_pkg::apb_state_e, apb_pkg::IDLE, apb_pkg::SETUP, apb_pkg::ACCESS, apb_pkg::DERR;
#(
    parameter int                NUM_SLV       = 4,
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE      = apb_pkg::SLV_BASE,
    parameter int                SLV_SPAN_LOG2 = apb_pkg::SLV_SPAN_LOG2,
    parameter int                TIMEOUT_CYC   = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      req,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    apb_state_e         state;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_SLV-1:0] dec_sel;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_hit;

    logic               pready_sel;
    logic               pslverr_sel;
    logic [DATA_W-1:0]  prdata_sel;

`ifdef APB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] tcnt;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    apb_addr_decoder #(
        .NUM_SLV       (NUM_SLV),
        .ADDR_W        (ADDR_W),
        .SLV_BASE      (SLV_BASE),
        .SLV_SPAN_LOG2 (SLV_SPAN_LOG2),
        .IDX_W         (IDX_W)
    ) u_dec (
        .addr (addr),
        .sel  (dec_sel),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    // Only the addressed slave's response is ever looked at.
    assign pready_sel  = PREADY[idx_q];
    assign pslverr_sel = PSLVERR[idx_q];
    assign prdata_sel  = PRDATA[idx_q*DATA_W +: DATA_W];

    always_ff @(posedge PCLK) begin
        // NOTE: all registered state uses non-blocking assignment so every
        // read in this block sees the value from before the clock edge.
        if (!PRESET) begin
            state   <= IDLE;
            idx_q   <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        PADDR  <= addr;
                        PWRITE <= write;
                        if (write) PWDATA <= wdata;
                        idx_q  <= dec_idx;
                        busy   <= 1'b1;
                        if (dec_hit) begin
                            PSEL  <= dec_sel;
                            state <= SETUP;
                        end else begin
                            state <= DERR;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                ACCESS: begin
                    // A slave answering on the last permitted cycle still completes.
                    if (pready_sel) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        err     <= pslverr_sel;
                        rdata   <= PWRITE ? '0 : prdata_sel;
                        state   <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
`endif
                end
                DERR: begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    err   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Self-checking bench for apb_master_nslv: vector table plus hand-written
// sequences for busy-ignore, reset abort and hung-slave behaviour.
module tb_apb_master_nslv;

    localparam int NUM_SLV     = 4;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic                      PCLK;
    logic                      PRESET;
    logic                      req;
    logic                      write;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W-1:0]         rdata;
    logic                      ready;
    logic                      err;
    logic                      busy;
    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PENABLE;
    logic [NUM_SLV-1:0]        PSEL;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    apb_master_nslv #(
        .NUM_SLV     (NUM_SLV),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (req),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .busy    (busy),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected completions, consumed by the monitor on each ready pulse.
    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_en = 1'b0;

    always @(negedge PCLK) begin
        if (mon_en) begin
            if (ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'(ready), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_err", 32'(err), 32'(mon_e.err));
                    check("resp_rdata", rdata, mon_e.rdata);
                end
            end else begin
                check("idle_err", 32'(err), 32'd0);
                check("idle_rdata", rdata, 32'd0);
            end
        end
    end

    // Slave model: the targeted slave answers after cur_waits ACCESS cycles;
    // every other slave drives the opposite values so any mis-steering shows.
    int          cur_tgt    = 0;
    int          cur_waits  = 0;
    logic        cur_slverr = 1'b0;
    logic [31:0] cur_prdata = '0;
    logic        stall      = 1'b0;
    int          acc_cnt    = 0;
    logic        rdy;

    always @(negedge PCLK) begin
        if (PENABLE) begin
            rdy = !stall && (acc_cnt >= cur_waits);
            acc_cnt++;
        end else begin
            rdy     = 1'b0;
            acc_cnt = 0;
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            PREADY[i]                = (i == cur_tgt) ? rdy : ~rdy;
            PSLVERR[i]               = (i == cur_tgt) ? cur_slverr : ~cur_slverr;
            PRDATA[i*DATA_W +: DATA_W] = (i == cur_tgt) ? cur_prdata : ~cur_prdata;
        end
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          tgt;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic        hit;
        logic [3:0]  psel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] last_wd = '0;

    // Called just after a falling edge; returns just after the falling edge of the ready cycle.
    task automatic run_vec(input vec_t v);
        int lat;
        int exp_lat;
        req        = 1'b1;
        write      = v.write;
        addr       = v.addr;
        wdata      = v.wdata;
        cur_tgt    = v.tgt;
        cur_waits  = v.waits;
        cur_slverr = v.slverr;
        cur_prdata = v.prdata;
        if (v.write) last_wd = v.wdata;
        sb_q.push_back('{v.exp_err, v.exp_rdata});
        @(posedge PCLK);
        #1;
        req   = 1'b0;
        addr  = 32'hFFFF_FFFF;
        wdata = ~v.wdata;
        @(negedge PCLK);
        check("setup_busy", 32'(busy), 32'd1);
        check("setup_psel", 32'(PSEL), v.hit ? 32'(v.psel) : 32'd0);
        check("setup_penable", 32'(PENABLE), 32'd0);
        check("paddr", PADDR, v.addr);
        check("pwrite", 32'(PWRITE), 32'(v.write));
        check("pwdata", PWDATA, last_wd);
        exp_lat = v.hit ? 3 + v.waits : 2;
        lat = 1;
        while (!ready && lat < 64) begin
            @(negedge PCLK);
            lat++;
            if (!ready) begin
                check("access_psel", 32'(PSEL), 32'(v.psel));
                check("access_penable", 32'(PENABLE), 32'd1);
                check("access_busy", 32'(busy), 32'd1);
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("done_psel", 32'(PSEL), 32'd0);
        check("done_penable", 32'(PENABLE), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int en_cycles;
        int busy_cycles;

        vecs[0]  = '{1'b1, 32'h1000_0000, 32'h0000_1111, apb_pkg::RAM,  0,  1'b0, 32'hAAAA_0000, 1'b1, 4'b0001, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h1000_3004, 32'h0,         apb_pkg::GPIO, 3,  1'b0, 32'hDEAD_BEEF, 1'b1, 4'b1000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h2000_0000, 32'h0,         apb_pkg::RAM,  0,  1'b0, 32'h0000_0001, 1'b0, 4'b0000, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h1000_1000, 32'h0000_2222, apb_pkg::GPO,  0,  1'b1, 32'h0000_0005, 1'b1, 4'b0010, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h1000_2FFC, 32'h0,         apb_pkg::GPI,  1,  1'b0, 32'h1234_5678, 1'b1, 4'b0100, 1'b0, 32'h1234_5678};
        vecs[5]  = '{1'b0, 32'h1000_4000, 32'h0,         apb_pkg::RAM,  0,  1'b0, 32'h0,         1'b0, 4'b0000, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h0FFF_FFFC, 32'h0,         apb_pkg::RAM,  0,  1'b0, 32'h0,         1'b0, 4'b0000, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h1000_0010, 32'h0,         apb_pkg::RAM,  2,  1'b1, 32'hA5A5_5A5A, 1'b1, 4'b0001, 1'b1, 32'hA5A5_5A5A};
        vecs[8]  = '{1'b1, 32'h1000_3FFC, 32'h3333_4444, apb_pkg::GPIO, 0,  1'b0, 32'h9999_9999, 1'b1, 4'b1000, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'hFFFF_F000, 32'h5555_AAAA, apb_pkg::RAM,  0,  1'b0, 32'h0,         1'b0, 4'b0000, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h1000_1008, 32'h0,         apb_pkg::GPO,  0,  1'b0, 32'h0BAD_F00D, 1'b1, 4'b0010, 1'b0, 32'h0BAD_F00D};
        vecs[11] = '{1'b0, 32'h1000_0004, 32'h0,         apb_pkg::RAM,  15, 1'b0, 32'h0F0F_0F0F, 1'b1, 4'b0001, 1'b0, 32'h0F0F_0F0F};

        PRESET = 1'b0;
        req    = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        repeat (3) @(negedge PCLK);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        PRESET = 1'b1;
        mon_en = 1'b1;
        @(negedge PCLK);

        // Back-to-back: each request is raised in the previous ready cycle.
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // A request while busy is dropped without touching the bus registers.
        cur_tgt = apb_pkg::GPI; cur_waits = 4; cur_slverr = 1'b0; cur_prdata = 32'h7777_0000;
        req = 1'b1; write = 1'b0; addr = 32'h1000_2000;
        sb_q.push_back('{1'b0, 32'h7777_0000});
        @(posedge PCLK); #1 req = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        req = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'hCAFE_F00D;
        @(posedge PCLK); #1 req = 1'b0; write = 1'b0;
        @(negedge PCLK);
        check("ign_paddr", PADDR, 32'h1000_2000);
        check("ign_pwrite", 32'(PWRITE), 32'd0);
        check("ign_pwdata", PWDATA, last_wd);
        check("ign_psel", 32'(PSEL), 32'b0100);
        n = 0;
        while (!ready && n < 32) begin
            @(negedge PCLK);
            n++;
        end
        check("ign_latency", 32'(n), 32'd4);
        @(negedge PCLK);
        check("ign_not_queued", 32'(busy), 32'd0);
        check("ign_no_psel", 32'(PSEL), 32'd0);

        // Reset in the middle of ACCESS kills the transfer with no ready pulse.
        stall = 1'b1; cur_tgt = apb_pkg::RAM;
        req = 1'b1; write = 1'b0; addr = 32'h1000_0000;
        @(posedge PCLK); #1 req = 1'b0;
        repeat (3) @(negedge PCLK);
        check("abort_penable_before", 32'(PENABLE), 32'd1);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        check("abort_psel", 32'(PSEL), 32'd0);
        check("abort_penable", 32'(PENABLE), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b1; stall = 1'b0; last_wd = '0;
        repeat (8) @(negedge PCLK);
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Hung slave: the selected PREADY never rises.
        stall = 1'b1; cur_tgt = apb_pkg::GPO;
        req = 1'b1; write = 1'b0; addr = 32'h1000_1000;
`ifdef APB_TIMEOUT_EN
        sb_q.push_back('{1'b1, 32'h0});
`endif
        @(posedge PCLK); #1 req = 1'b0;
`ifdef APB_TIMEOUT_EN
        n = 0; en_cycles = 0;
        while (!ready && n < 200) begin
            @(negedge PCLK);
            n++;
            if (PENABLE) en_cycles++;
        end
        check("to_penable_cycles", 32'(en_cycles), 32'(TIMEOUT_CYC));
        check("to_latency", 32'(n), 32'(TIMEOUT_CYC + 2));
        @(negedge PCLK);
        check("to_idle_busy", 32'(busy), 32'd0);
`else
        @(negedge PCLK);
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy && !ready) busy_cycles++;
            @(negedge PCLK);
        end
        check("hang_busy_cycles", 32'(busy_cycles), 32'd100);
        check("hang_penable", 32'(PENABLE), 32'd1);
        PRESET = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
`endif
        stall = 1'b0;
        @(negedge PCLK);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
